// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one memory read channel and one write channel
// between the instruction cache (client 0) and the data cache (client 1).
// The read path keeps one read outstanding and steers its return beats back
// to the granted client. The write path is a one-entry buffer for dcache
// evictions. A read to the buffered line waits until that write is
// acknowledged.
// Optional build macro ARB_RR_EN selects round-robin arbitration between
// the two caches. Without it, the dcache has fixed priority.
module cache_mem_arbiter #(
  parameter int LINE_OFF_W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   cl_rd_req,
  input  logic [5:0]   cl_rd_type,
  input  logic [63:0]  cl_rd_addr,
  output logic [1:0]   cl_rd_rdy,
  output logic [1:0]   cl_ret_valid,
  output logic [1:0]   cl_ret_last,
  output logic [31:0]  cl_ret_data,
  input  logic         dc_wr_req,
  input  logic [2:0]   dc_wr_type,
  input  logic [31:0]  dc_wr_addr,
  input  logic [3:0]   dc_wr_wstrb,
  input  logic [127:0] dc_wr_data,
  output logic         dc_wr_rdy,
  output logic         mem_rd_req,
  output logic [2:0]   mem_rd_type,
  output logic [31:0]  mem_rd_addr,
  input  logic         mem_rd_rdy,
  input  logic         mem_ret_valid,
  input  logic         mem_ret_last,
  input  logic [31:0]  mem_ret_data,
  output logic         mem_wr_req,
  output logic [2:0]   mem_wr_type,
  output logic [31:0]  mem_wr_addr,
  output logic [3:0]   mem_wr_wstrb,
  output logic [127:0] mem_wr_data,
  input  logic         mem_wr_rdy,
  input  logic         mem_wr_bvalid
);

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wr_state_t;

  rd_state_t    rd_state;
  wr_state_t    wr_state;
  logic         gnt;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic [2:0]   wbuf_type;
  logic [31:0]  wbuf_addr;
  logic [3:0]   wbuf_wstrb;
  logic [127:0] wbuf_data;
  logic [1:0]   hazard;
  logic [1:0]   eligible;
  logic         sel;
  logic         grant;
  logic         ret_beat;

`ifdef ARB_RR_EN
  logic         last_gnt;
`endif

  // Find which requesting clients are blocked by the buffered write, then pick a winner
  always_comb begin
    hazard[0] = (wr_state != W_IDLE) &&
                (cl_rd_addr[31:LINE_OFF_W] == wbuf_addr[31:LINE_OFF_W]);
    hazard[1] = (wr_state != W_IDLE) &&
                (cl_rd_addr[63:32+LINE_OFF_W] == wbuf_addr[31:LINE_OFF_W]);
    eligible  = cl_rd_req & ~hazard;
`ifdef ARB_RR_EN
    sel = (&eligible) ? ~last_gnt : eligible[1];
`else
    sel = eligible[1];
`endif
    grant     = (rd_state == R_IDLE) && (|eligible) && !reset;
    cl_rd_rdy = grant ? (sel ? 2'b10 : 2'b01) : 2'b00;
  end

  // Pass return beats straight through to the client that owns the read
  always_comb begin
    ret_beat     = (rd_state == R_DATA) && mem_ret_valid;
    cl_ret_valid = gnt ? {ret_beat, 1'b0} : {1'b0, ret_beat};
    cl_ret_last  = gnt ? {ret_beat & mem_ret_last, 1'b0}
                       : {1'b0, ret_beat & mem_ret_last};
  end

  assign cl_ret_data  = mem_ret_data;
  assign mem_rd_req   = (rd_state == R_REQ);
  assign mem_rd_type  = rd_type;
  assign mem_rd_addr  = rd_addr;
  assign dc_wr_rdy    = (wr_state == W_IDLE);
  assign mem_wr_req   = (wr_state == W_REQ);
  assign mem_wr_type  = wbuf_type;
  assign mem_wr_addr  = wbuf_addr;
  assign mem_wr_wstrb = wbuf_wstrb;
  assign mem_wr_data  = wbuf_data;

  // Read FSM: grant, latch the request, issue it, then wait for the last beat
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state <= R_IDLE;
      gnt      <= 1'b0;
      rd_type  <= 3'b000;
      rd_addr  <= 32'h0;
`ifdef ARB_RR_EN
      last_gnt <= 1'b1;
`endif
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (grant) begin
            rd_state <= R_REQ;
            gnt      <= sel;
            rd_type  <= sel ? cl_rd_type[5:3] : cl_rd_type[2:0];
            rd_addr  <= sel ? cl_rd_addr[63:32] : cl_rd_addr[31:0];
`ifdef ARB_RR_EN
            last_gnt <= sel;
`endif
          end
        end
        R_REQ: begin
          if (mem_rd_rdy) rd_state <= R_DATA;
        end
        R_DATA: begin
          if (mem_ret_valid && mem_ret_last) rd_state <= R_IDLE;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Write FSM: capture an eviction, offer it to the bridge, wait for the response
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state   <= W_IDLE;
      wbuf_type  <= 3'b000;
      wbuf_addr  <= 32'h0;
      wbuf_wstrb <= 4'h0;
      wbuf_data  <= 128'h0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (dc_wr_req) begin
            wr_state   <= W_REQ;
            wbuf_type  <= dc_wr_type;
            wbuf_addr  <= dc_wr_addr;
            wbuf_wstrb <= dc_wr_wstrb;
            wbuf_data  <= dc_wr_data;
          end
        end
        W_REQ: begin
          if (mem_wr_rdy) wr_state <= W_RESP;
        end
        W_RESP: begin
          if (mem_wr_bvalid) wr_state <= W_IDLE;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

endmodule
